clk_div_ctrl: RTL and testbench

Run-time controller for a programmable clock divider.
- Produces a divided clock `clk_out` with period 2*H clk cycles and 50% duty.
- H (the half-period) is reprogrammed through a valid/ready handshake and applied only at a half-period boundary.
- Start/stop via `en` never produces a truncated high phase, which keeps downstream logic (display scan, debounce, baud sampling) glitch-free.

---
 rtl/clk_div_ctrl.sv | 171 +++++++++++++++++
 tb/tb_clk_div_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_ctrl.sv
// Run-time controller for a programmable clock divider.
// Produces clk_out with period 2*H clk cycles and 50% duty. H is reprogrammed
// through a valid/ready handshake and only takes effect at a half-period
// boundary (or while stopped). Stopping via en never truncates a high phase:
// a high phase in progress is drained to its full length before stopping.
module clk_div_ctrl #(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned DEF_HALF = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_half,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             rise_tick,
  output logic             fall_tick,
  output logic             running
);

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Controller state and half-period counter.
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;

  // Active half-period and the single-entry pending slot behind the handshake.
  logic [CNT_W-1:0] r_half;
  logic [CNT_W-1:0] r_pend;

  // Registered outputs.
  logic r_clk_out;
  logic r_rise;
  logic r_fall;
  logic r_running;
  logic r_cfg_ready;
  logic r_cfg_err;

  // Combinational decode of the current cycle.
  logic w_at_end;
  logic w_count;
  logic w_toggle;
  logic w_accept;
  logic w_reject;
  logic w_apply;

  // Last cycle of the current half-period. r_cnt never exceeds r_half-1,
  // and r_half is never 0, so the subtraction cannot wrap.
  assign w_at_end = (r_cnt == (r_half - CNT_W'(1)));

  // The counter advances in RUN and DRAIN, except for the cycle where RUN is
  // stopped during a low phase (that cycle goes straight to STOP).
  assign w_count  = (r_state == ST_DRAIN) ||
                    ((r_state == ST_RUN) && (en || r_clk_out));

  // clk_out changes level in this cycle.
  assign w_toggle = w_count && w_at_end;

  // Handshake: only offers seen while ready count; zero is rejected.
  assign w_accept = cfg_valid && r_cfg_ready && (cfg_half != '0);
  assign w_reject = cfg_valid && r_cfg_ready && (cfg_half == '0);

  // A pending value (ready low) is applied while stopped, or at the toggle
  // so the new H governs the following half-period in full.
  assign w_apply  = !r_cfg_ready && ((r_state == ST_STOP) || w_toggle);

  // Main FSM: state, counter, divided clock and edge ticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_STOP;
      r_cnt     <= '0;
      r_clk_out <= 1'b0;
      r_rise    <= 1'b0;
      r_fall    <= 1'b0;
      r_running <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only; the tick
      // defaults below are then overridden later in the same block, which
      // makes them single-cycle pulses without extra clearing logic.
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      case (r_state)
        ST_STOP: begin
          r_cnt     <= '0;
          r_clk_out <= 1'b0;
          if (en) begin
            r_state   <= ST_RUN;
            r_running <= 1'b1;
          end else begin
            r_running <= 1'b0;
          end
        end

        ST_RUN, ST_DRAIN: begin
          if (!w_count) begin
            // Stop requested during a low phase: the low level just continues.
            r_state   <= ST_STOP;
            r_running <= 1'b0;
            r_cnt     <= '0;
          end else begin
            if (w_at_end) begin
              r_cnt     <= '0;
              r_clk_out <= ~r_clk_out;
              r_rise    <= ~r_clk_out;
              r_fall    <= r_clk_out;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end

            if (en) begin
              // Resuming from DRAIN keeps cnt and clk_out untouched.
              r_state   <= ST_RUN;
              r_running <= 1'b1;
            end else if (w_at_end) begin
              // Only reachable with clk_out high: this toggle is the fall.
              r_state   <= ST_STOP;
              r_running <= 1'b0;
            end else begin
              // Let the high phase finish at full length.
              r_state   <= ST_DRAIN;
              r_running <= 1'b1;
            end
          end
        end

        default: begin
          r_state   <= ST_STOP;
          r_cnt     <= '0;
          r_clk_out <= 1'b0;
          r_running <= 1'b0;
        end
      endcase
    end
  end

  // Configuration handshake: accept into the pending slot, apply at a boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_half      <= CNT_W'(DEF_HALF);
      r_pend      <= '0;
      r_cfg_ready <= 1'b1;
      r_cfg_err   <= 1'b0;
    end else begin
      r_cfg_err <= w_reject;
      // Accept requires ready high and apply requires ready low, so the two
      // branches are mutually exclusive; an offer in the apply cycle is ignored.
      if (w_accept) begin
        r_pend      <= cfg_half;
        r_cfg_ready <= 1'b0;
      end else if (w_apply) begin
        r_half      <= r_pend;
        r_cfg_ready <= 1'b1;
      end
    end
  end

  // Output mapping.
  assign clk_out   = r_clk_out;
  assign rise_tick = r_rise;
  assign fall_tick = r_fall;
  assign running   = r_running;
  assign cfg_ready = r_cfg_ready;
  assign cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: directed scenarios followed by random
// stimulus, every cycle compared against a countdown-based behavioural model.
module tb_clk_div_ctrl;

  localparam int unsigned CNT_W    = 16;
  localparam int unsigned DEF_HALF = 2;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_half;
  logic             cfg_ready;
  logic             cfg_err;
  logic             clk_out;
  logic             rise_tick;
  logic             fall_tick;
  logic             running;

  clk_div_ctrl #(.CNT_W(CNT_W), .DEF_HALF(DEF_HALF)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_half  (cfg_half),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .clk_out   (clk_out),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick),
    .running   (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Behavioural model: mode, output level, cycles left in this half-period,
  // current half-period and a queue holding at most one pending value.
  typedef enum {M_STOP, M_RUN, M_DRAIN} mode_e;
  mode_e            m_mode;
  bit               m_level;
  int               m_left;
  int               m_half;
  logic [CNT_W-1:0] m_pend[$];
  bit               e_rise, e_fall, e_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode  = M_STOP;
    m_level = 1'b0;
    m_left  = 0;
    m_half  = DEF_HALF;
    m_pend.delete();
    e_rise  = 1'b0;
    e_fall  = 1'b0;
    e_err   = 1'b0;
  endtask

  // Advance the model by one clk edge using the inputs presented at that edge.
  task automatic model_step();
    bit had_pend;
    bit accept;
    bit toggle;
    had_pend = (m_pend.size() != 0);
    accept   = cfg_valid && !had_pend && (cfg_half != 0);
    e_err    = cfg_valid && !had_pend && (cfg_half == 0);
    toggle   = 1'b0;
    e_rise   = 1'b0;
    e_fall   = 1'b0;
    if (m_mode == M_STOP) begin
      if (had_pend) m_half = int'(m_pend.pop_front());
      if (en) begin
        m_mode = M_RUN;
        m_left = m_half;
      end
    end else if (m_mode == M_RUN && !en && !m_level) begin
      m_mode = M_STOP;
    end else begin
      if (m_left == 1) begin
        toggle  = 1'b1;
        m_level = !m_level;
        e_rise  = m_level;
        e_fall  = !m_level;
        if (had_pend) m_half = int'(m_pend.pop_front());
        m_left  = m_half;
      end else begin
        m_left--;
      end
      if (en)          m_mode = M_RUN;
      else if (toggle) m_mode = M_STOP;
      else             m_mode = M_DRAIN;
    end
    if (accept) m_pend.push_back(cfg_half);
  endtask

  task automatic compare_all();
    check("clk_out",   32'(clk_out),   32'(m_level));
    check("rise_tick", 32'(rise_tick), 32'(e_rise));
    check("fall_tick", 32'(fall_tick), 32'(e_fall));
    check("cfg_ready", 32'(cfg_ready), 32'(m_pend.size() == 0));
    check("cfg_err",   32'(cfg_err),   32'(e_err));
    check("running",   32'(running),   32'(m_mode != M_STOP));
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic step();
    @(posedge clk);
    model_step();
    cyc++;
    @(negedge clk);
    compare_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Offer one value for a single cycle once the model says the slot is free.
  task automatic offer(input logic [CNT_W-1:0] h);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (m_pend.size() == 0) found = 1'b1;
      else step();
    end
    check("offer_wait", 32'(found), 32'd1);
    cfg_valid = 1'b1;
    cfg_half  = h;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_rise();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      if (e_rise) found = 1'b1;
    end
    check("rise_wait", 32'(found), 32'd1);
  endtask

  task automatic wait_stop();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (m_mode == M_STOP) found = 1'b1;
      else step();
    end
    check("stop_wait", 32'(found), 32'd1);
  endtask

  logic [7:0] pat_clk;
  logic [7:0] pat_rise;
  logic [7:0] pat_fall;

  initial begin
    rst_n     = 1'b0;
    en        = 1'b0;
    cfg_valid = 1'b0;
    cfg_half  = '0;
    model_reset();
    repeat (3) @(negedge clk);

    // Reset values.
    check("rst_clk_out",   32'(clk_out),   32'd0);
    check("rst_rise",      32'(rise_tick), 32'd0);
    check("rst_fall",      32'(fall_tick), 32'd0);
    check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    check("rst_cfg_err",   32'(cfg_err),   32'd0);
    check("rst_running",   32'(running),   32'd0);
    rst_n = 1'b1;
    step();

    // Default H=2: clk_out 0,0,1,1,0,0,1,1 after enabling.
    pat_clk  = 8'b1100_1100;
    pat_rise = 8'b0100_0100;
    pat_fall = 8'b0001_0000;
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check("tp1_clk",  32'(clk_out),   32'(pat_clk[i]));
      check("tp1_rise", 32'(rise_tick), 32'(pat_rise[i]));
      check("tp1_fall", 32'(fall_tick), 32'(pat_fall[i]));
      check("tp1_run",  32'(running),   32'd1);
    end

    // H=5 offered right after a rise: current high stays 2, then period 10.
    wait_rise();
    offer(16'd5);
    check("tp2_ready_low", 32'(cfg_ready), 32'd0);
    run(30);

    // Zero offer is rejected with a single err pulse, ready stays high.
    offer(16'd0);
    check("tp3_err",   32'(cfg_err),   32'd1);
    check("tp3_ready", 32'(cfg_ready), 32'd1);
    step();
    check("tp3_err_gone", 32'(cfg_err), 32'd0);
    run(20);

    // H=3, en dropped one cycle into the high phase: full-length drain.
    en = 1'b0;
    wait_stop();
    offer(16'd3);
    run(2);
    en = 1'b1;
    wait_rise();
    step();
    en = 1'b0;
    run(8);
    check("tp4_stopped_clk", 32'(clk_out), 32'd0);
    check("tp4_stopped_run", 32'(running), 32'd0);
    // en dropped during a low phase: STOP next cycle.
    en = 1'b1;
    wait_rise();
    run(4);
    en = 1'b0;
    run(4);

    // H=1 toggles every cycle; then H=4 programmed while stopped.
    wait_stop();
    offer(16'd1);
    en = 1'b1;
    run(10);
    en = 1'b0;
    wait_stop();
    offer(16'd4);
    run(2);
    en = 1'b1;
    run(14);

    // Random stimulus.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) en = ~en;
      cfg_valid = ($urandom_range(0, 5) == 0);
      cfg_half  = CNT_W'($urandom_range(0, 7));
      step();
    end
    cfg_valid = 1'b0;

    // Reset mid high phase with a pending value.
    en = 1'b1;
    offer(16'd6);
    run(20);
    wait_rise();
    offer(16'd3);
    check("tp6_pending", 32'(cfg_ready), 32'd0);
    check("tp6_high",    32'(clk_out),   32'd1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("tp6_rst_clk",   32'(clk_out),   32'd0);
    check("tp6_rst_ready", 32'(cfg_ready), 32'd1);
    check("tp6_rst_run",   32'(running),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run(12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
